alu_irq_capture: RTL
====================

# alu_irq_capture

Downstream consumer of the ALU result/interrupt outputs. Detects each `alu_irq` assertion, snapshots `alu_out` into a small FIFO, drives the `alu_irq_clr` handshake back to the ALU and exposes the captured results to the host through a valid/ready port. Sticky flags report dropped events and an interrupt line that does not release.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CLR_CYCLES`, 2: cycles `alu_irq_clr` is held high per event; 1..15.
- `TIMEOUT`, 8: cycles to wait for `alu_irq` to drop before retrying the clear; 2..255.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `alu_rst` in 1: asynchronous, active-low reset.
- `alu_out` in 8: ALU result, sampled on capture.
- `alu_irq` in 1: ALU interrupt request, level.
- `alu_irq_clr` out 1: interrupt clear to ALU, registered.
- `evt_data` out 8: FIFO head; 8'h00 when empty.
- `evt_valid` out 1: FIFO non-empty.
- `evt_ready` in 1: host accepts head when `evt_valid && evt_ready`.
- `evt_count` out $clog2(DEPTH+1): entries held.
- `ovf` out 1: sticky, event dropped because FIFO full.
- `stuck` out 1: sticky, `alu_irq` still high after `TIMEOUT`.
- `flag_clr` in 1: synchronous clear of `ovf` and `stuck`.

## Operation
- FSM states: IDLE, CLEAR, WAIT_LOW.
- IDLE: `alu_irq`=1 at an edge → push `alu_out` (same edge) and go to CLEAR.
- CLEAR: `alu_irq_clr`=1 for exactly `CLR_CYCLES` cycles, then WAIT_LOW.
- WAIT_LOW: `alu_irq`=0 sampled → IDLE. If `alu_irq` stays 1 for `TIMEOUT` consecutive cycles → set `stuck` and go back to CLEAR (retry, no new push).
- One push per `alu_irq` assertion. A level held high never pushes twice.
- Push when full:
  - With a simultaneous pop: the push is accepted.
  - Otherwise: data dropped, `ovf` set, and the clear handshake still runs.
- Pop when `evt_valid && evt_ready`. Pop when empty is ignored.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `evt_count` is updated as +1, −1 or 0 for simultaneous push and pop.
- `flag_clr` coinciding with a new set event: the set wins.

## Timing
- Reset (async assert, sync release) puts all outputs at 0: `alu_irq_clr`=0, `evt_valid`=0, `evt_data`=8'h00, `evt_count`=0, `ovf`=0, `stuck`=0. FSM = IDLE, FIFO empty, timers 0.
- Reset asserted mid-handshake drops `alu_irq_clr` immediately (async). FIFO contents are lost.
- Capture latency:
  - `alu_irq` sampled high at edge N → entry written at N.
  - `evt_valid`=1 after N.
  - `alu_irq_clr`=1 from after N through after N+`CLR_CYCLES`−1, and 0 after N+`CLR_CYCLES`.
- Pop at edge M → next head (or 8'h00) visible after M. Count changes after M.
- WAIT_LOW timer starts counting at the first WAIT_LOW edge. `stuck` is set at the edge where the count reaches `TIMEOUT`.
- `evt_data` and `evt_valid` are registered outputs. No combinational path from `evt_ready` to any output.

## Configuration
- `ALU_IRQ_CAPTURE_TS_EN` defined:
  - Adds a free-running 16-bit cycle counter, reset to 0, wrapping at 16'hFFFF.
  - Adds output `evt_ts` [15:0], stored alongside each entry with the counter value at the push edge.
  - `evt_ts` reads 16'h0000 when empty.
- Not defined: no counter, no `evt_ts` port, FIFO is 8 bits wide.

## Test plan
- Reset then idle 10 cycles → all outputs 0, `evt_count`=0.
- `alu_out`=8'hF8 and `alu_irq` pulse high until `alu_irq_clr` is seen, `evt_ready`=0 → `evt_data`=8'hF8, `evt_valid`=1, `evt_count`=1, `alu_irq_clr` high exactly 2 cycles.
- Five events (8'hFF, 8'h00, 8'h83, 8'hF1, 8'hF4) with `evt_ready`=0, `DEPTH`=4 → `evt_count`=4, `ovf`=1, five clear pulses. Popping returns FF, 00, 83, F1 in order, then `evt_valid`=0 and `evt_data`=8'h00.
- Full FIFO with a push and a pop on the same edge → `evt_count` stays 4, `ovf` stays 0, and the new value is the last entry popped.
- `alu_irq` held high 30 cycles → `stuck`=1 after CLR(2)+TIMEOUT(8) cycles, one FIFO entry only, clear pulse repeats. Then `flag_clr`=1 → `stuck`=0.
- `alu_rst`=0 asserted during CLEAR → `alu_irq_clr` drops without waiting for a clock, `evt_count`=0. With `ALU_IRQ_CAPTURE_TS_EN` defined, an event at cycle 20 after reset → `evt_ts`=16'd20.

Source files
------------

// File: rtl/alu_irq_capture.sv
// ============================================================================
// Module   : alu_irq_capture
// Brief    : Captures alu_out on each alu_irq assertion into a FIFO, runs the
//            alu_irq_clr handshake and flags overflow / stuck interrupts.
//            Optional macro ALU_IRQ_CAPTURE_TS_EN adds a 16-bit timestamp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_irq_capture #(
    parameter int DEPTH      = 4,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 8
) (
    input  logic                         clk,
    input  logic                         alu_rst,
    input  logic [7:0]                   alu_out,
    input  logic                         alu_irq,
    output logic                         alu_irq_clr,
    output logic [7:0]                   evt_data,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [$clog2(DEPTH+1)-1:0]   evt_count,
    output logic                         ovf,
    output logic                         stuck,
    input  logic                         flag_clr
`ifdef ALU_IRQ_CAPTURE_TS_EN
    ,
    output logic [15:0]                  evt_ts
`endif
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = $clog2(DEPTH + 1);
`ifdef ALU_IRQ_CAPTURE_TS_EN
    localparam int C_ENT_W = 24;
`else
    localparam int C_ENT_W = 8;
`endif
    localparam logic [C_CNT_W-1:0] C_FULL     = C_CNT_W'(DEPTH);
    localparam logic [3:0]         C_CLR_LAST = 4'(CLR_CYCLES - 1);
    localparam logic [7:0]         C_TO_LAST  = 8'(TIMEOUT - 1);

    localparam logic [1:0] C_ST_IDLE     = 2'd0;
    localparam logic [1:0] C_ST_CLEAR    = 2'd1;
    localparam logic [1:0] C_ST_WAIT_LOW = 2'd2;

    logic [1:0]         r_state, w_state_d;
    logic [3:0]         r_clr_cnt, w_clr_cnt_d;
    logic [7:0]         r_wait_cnt, w_wait_cnt_d;
    logic               r_clr, w_clr_d;
    logic               w_push_req, w_stuck_evt;

    logic [C_ENT_W-1:0] r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_d;
    logic [C_CNT_W-1:0] r_count, w_count_d;
    logic [C_ENT_W-1:0] r_head, w_head_d, w_entry_in;
    logic               r_valid, r_ovf, r_stuck;
    logic               w_full, w_pop, w_push, w_ovf_evt;

`ifdef ALU_IRQ_CAPTURE_TS_EN
    logic [15:0] r_ts;

    always_ff @(posedge clk or negedge alu_rst) begin
        if (!alu_rst) r_ts <= 16'h0000;
        else          r_ts <= r_ts + 16'd1;
    end

    assign w_entry_in = {r_ts, alu_out};
    assign evt_ts     = r_head[23:8];
`else
    assign w_entry_in = alu_out;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge alu_rst) begin
        if (!alu_rst) begin
            r_state    <= C_ST_IDLE;
            r_clr_cnt  <= 4'd0;
            r_wait_cnt <= 8'd0;
            r_clr      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_clr_cnt  <= w_clr_cnt_d;
            r_wait_cnt <= w_wait_cnt_d;
            r_clr      <= w_clr_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_d    = r_state;
        w_clr_cnt_d  = r_clr_cnt;
        w_wait_cnt_d = r_wait_cnt;
        case (r_state)
            C_ST_IDLE: begin
                if (alu_irq) begin
                    w_state_d   = C_ST_CLEAR;
                    w_clr_cnt_d = 4'd0;
                end
            end
            C_ST_CLEAR: begin
                if (r_clr_cnt == C_CLR_LAST) begin
                    w_state_d    = C_ST_WAIT_LOW;
                    w_wait_cnt_d = 8'd0;
                end else begin
                    w_clr_cnt_d = r_clr_cnt + 4'd1;
                end
            end
            C_ST_WAIT_LOW: begin
                if (!alu_irq) begin
                    w_state_d = C_ST_IDLE;
                end else if (r_wait_cnt == C_TO_LAST) begin
                    // Retry the clear without pushing a new entry.
                    w_state_d   = C_ST_CLEAR;
                    w_clr_cnt_d = 4'd0;
                end else begin
                    w_wait_cnt_d = r_wait_cnt + 8'd1;
                end
            end
            default: w_state_d = C_ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_push_req  = (r_state == C_ST_IDLE) && alu_irq;
        w_stuck_evt = (r_state == C_ST_WAIT_LOW) && alu_irq && (r_wait_cnt == C_TO_LAST);
        w_clr_d     = (w_state_d == C_ST_CLEAR);
    end

    // ---------------- FIFO ----------------
    assign w_full    = (r_count == C_FULL);
    assign w_pop     = r_valid && evt_ready;
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_ovf_evt = w_push_req && w_full && !w_pop;

    always_comb begin
        w_rd_ptr_d = w_pop ? r_rd_ptr + C_PTR_W'(1) : r_rd_ptr;
        w_count_d  = r_count;
        if (w_push && !w_pop)      w_count_d = r_count + C_CNT_W'(1);
        else if (!w_push && w_pop) w_count_d = r_count - C_CNT_W'(1);
        // Head slot being written this edge must bypass the memory.
        if (w_count_d == '0)                         w_head_d = '0;
        else if (w_push && (w_rd_ptr_d == r_wr_ptr)) w_head_d = w_entry_in;
        else                                         w_head_d = r_mem[w_rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry_in;
    end

    always_ff @(posedge clk or negedge alu_rst) begin
        if (!alu_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_stuck  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            r_rd_ptr <= w_rd_ptr_d;
            r_count  <= w_count_d;
            r_head   <= w_head_d;
            r_valid  <= (w_count_d != '0);
            if (w_ovf_evt)     r_ovf <= 1'b1;
            else if (flag_clr) r_ovf <= 1'b0;
            if (w_stuck_evt)   r_stuck <= 1'b1;
            else if (flag_clr) r_stuck <= 1'b0;
        end
    end

    assign alu_irq_clr = r_clr;
    assign evt_data    = r_head[7:0];
    assign evt_valid   = r_valid;
    assign evt_count   = r_count;
    assign ovf         = r_ovf;
    assign stuck       = r_stuck;

endmodule

`default_nettype wire
